// File: rtl/rhd_emu_pkg.sv
// Shared constants for the RHD2000 headstage emulator: opcodes, register map,
// the "INTAN" identification ROM and the frame FSM state encoding.
package rhd_emu_pkg;

    localparam logic [1:0]  OP_CONVERT = 2'b00;
    localparam logic [1:0]  OP_CAL     = 2'b01;
    localparam logic [1:0]  OP_WRITE   = 2'b10;
    localparam logic [1:0]  OP_READ    = 2'b11;

    localparam logic [15:0] CAL_WORD   = 16'h5500;
    localparam int          REG_COUNT  = 22;
    localparam logic [5:0]  REG_CHIPID = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Read-only identification registers 40..44 spell "INTAN"
    function automatic logic [7:0] intan_byte(input logic [5:0] r);
        case (r)
            6'd40:   intan_byte = 8'h49;
            6'd41:   intan_byte = 8'h4E;
            6'd42:   intan_byte = 8'h54;
            6'd43:   intan_byte = 8'h41;
            6'd44:   intan_byte = 8'h4E;
            default: intan_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rhd_emu_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a one-cycle
// rise/fall pulse generator. Chain resets to 0 so a pin already high after
// reset produces a rise pulse once it has been synchronised.
module rhd_emu_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    // Shift the pin through the synchroniser and remember the last synced level
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= {sr[STAGES-2:0], din};
            prev <= sr[STAGES-1];
        end
    end

    assign rise = sr[STAGES-1] & ~prev;
    assign fall = ~sr[STAGES-1] & prev;

endmodule

// File: rtl/rhd_headstage_emulator.sv
// RHD2000 headstage SPI slave emulator. Oversamples cs/sclk/mosi, decodes
// 16-bit commands and returns each result two frames later on miso.
// Optional feature macro: RHD_EMU_DDR_EN (second stream B on the sclk-high half).
module rhd_headstage_emulator
    import rhd_emu_pkg::*;
#(
    parameter int NUM_CH        = 32,
    parameter int SEED          = 0,
    parameter int SEED_B_OFFSET = 32,
    parameter int CH_STEP       = 1,
    parameter int CHIP_ID       = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic [31:0] frame_cnt,
    output logic        err_short
);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;

    rhd_emu_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    rhd_emu_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // mosi only needs the same delay as sclk so it is sampled aligned with sclk_rise
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   mosi_s;

    // Synchronise mosi to line up with the synced sclk edge pulses
    always_ff @(posedge clk) begin
        if (rst) mosi_sr <= '0;
        else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    state_t                     state;
    logic                       armed;
    logic [15:0]                rx;
    logic [15:0]                tx_a;
    logic [4:0]                 bitcnt;
    logic [1:0][15:0]           pipe_a;
    logic [15:0]                sweep_cnt;
    logic [REG_COUNT-1:0][7:0]  regs;
`ifdef RHD_EMU_DDR_EN
    logic [15:0]                tx_b;
    logic [1:0][15:0]           pipe_b;
`endif

    logic [5:0]  arg;
    logic [31:0] conv_sum;
    logic [15:0] res_a;
    logic [15:0] res_b;
    logic        sweep_inc;

    // Decode the received command into its result word(s)
    always_comb begin
        arg       = rx[13:8];
        conv_sum  = 32'(SEED) + 32'(arg) * 32'(CH_STEP) + 32'(sweep_cnt);
        res_a     = 16'h0000;
        sweep_inc = 1'b0;
        case (rx[15:14])
            OP_CONVERT: begin
                if (int'(arg) < NUM_CH) res_a = conv_sum[15:0];
                sweep_inc = (arg == 6'd0);
            end
            // CALIBRATE (CAL_WORD) and every other 01 command answer zero
            OP_CAL:   res_a = 16'h0000;
            OP_WRITE: res_a = {8'hFF, rx[7:0]};
            OP_READ: begin
                if (int'(arg) < REG_COUNT) res_a = {8'h00, regs[arg[4:0]]};
                else if (arg == REG_CHIPID) res_a = {8'h00, 8'(CHIP_ID)};
                else                        res_a = {8'h00, intan_byte(arg)};
            end
            default: res_a = 16'h0000;
        endcase
        res_b = res_a;
`ifdef RHD_EMU_DDR_EN
        if (rx[15:14] == OP_CONVERT && int'(arg) < NUM_CH)
            res_b = res_a + 16'(SEED_B_OFFSET);
`endif
    end

    // Frame FSM: IDLE waits for cs fall, SHIFT moves bits, DONE commits the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            miso      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_word  <= 16'h0000;
            frame_cnt <= 32'd0;
            err_short <= 1'b0;
            rx        <= 16'h0000;
            tx_a      <= 16'h0000;
            bitcnt    <= 5'd0;
            pipe_a    <= '0;
            sweep_cnt <= 16'h0000;
            regs      <= '0;
`ifdef RHD_EMU_DDR_EN
            tx_b      <= 16'h0000;
            pipe_b    <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            err_short <= 1'b0;
            if (cs_rise) armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (armed && cs_fall) begin
                        tx_a   <= pipe_a[1];
                        miso   <= pipe_a[1][15];
`ifdef RHD_EMU_DDR_EN
                        tx_b   <= pipe_b[1];
`endif
                        bitcnt <= 5'd0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // cs rise takes priority over a coincident sclk edge
                    if (cs_rise) begin
                        miso <= 1'b0;
                        if (bitcnt == 5'd16) begin
                            state <= ST_DONE;
                        end else begin
                            err_short <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (sclk_rise) begin
                        if (bitcnt < 5'd16) rx <= {rx[14:0], mosi_s};
                        if (bitcnt != 5'd17) bitcnt <= bitcnt + 5'd1;
`ifdef RHD_EMU_DDR_EN
                        miso <= tx_b[15];
`endif
                    end else if (sclk_fall) begin
                        tx_a <= {tx_a[14:0], 1'b0};
                        miso <= tx_a[14];
`ifdef RHD_EMU_DDR_EN
                        tx_b <= {tx_b[14:0], 1'b0};
`endif
                    end
                end
                ST_DONE: begin
                    pipe_a    <= {pipe_a[0], res_a};
`ifdef RHD_EMU_DDR_EN
                    pipe_b    <= {pipe_b[0], res_b};
`endif
                    if (rx[15:14] == OP_WRITE && int'(arg) < REG_COUNT)
                        regs[arg[4:0]] <= rx[7:0];
                    if (sweep_inc) sweep_cnt <= sweep_cnt + 16'd1;
                    cmd_valid <= 1'b1;
                    cmd_word  <= rx;
                    frame_cnt <= frame_cnt + 32'd1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef RHD_EMU_DDR_EN
    // Stream B does not exist in single-rate builds
    logic unused_b;
    assign unused_b = ^res_b;
`endif

endmodule
